fp32_arith_unit: RTL and testbench



---
 rtl/fp32_arith_unit.sv | 152 +++++++++++++++
 tb/tb_fp32_arith_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fp32_arith_unit.sv
// fp32_arith_unit: two-stage binary32 add/multiply, truncating, FTZ.
// Multiplier is built only when FP32_ARITH_MULT_EN is defined.
module fp32_arith_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        In_Data_Valid,
  input  logic        Op,
  output logic [31:0] Data_Out,
  output logic        Out_Data_Valid
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] a_q, b_q, data_q, res_d;
  logic        op_q, v_q, ov_q;

  logic       sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [7:0] ea, eb;
  logic [31:0] fa, fb;

  assign sa = a_q[31];
  assign sb = b_q[31];
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign nan_a = (&ea) & (|a_q[22:0]);
  assign nan_b = (&eb) & (|b_q[22:0]);
  assign inf_a = (&ea) & ~(|a_q[22:0]);
  assign inf_b = (&eb) & ~(|b_q[22:0]);
  assign zero_a = ~(|ea);
  assign zero_b = ~(|eb);
  assign fa = zero_a ? {sa, 31'b0} : a_q;
  assign fb = zero_b ? {sb, 31'b0} : b_q;

  logic              sx, sy;
  logic [7:0]        ex, ey, d;
  logic [22:0]       mx_f, my_f;
  logic [4:0]        dd, lz;
  logic [26:0]       mx, my_s;
  logic [53:0]       ext;
  logic [27:0]       sum, nrm;
  logic signed [9:0] e_add;
  logic [31:0]       add_arith, add_res;

  // Adder: align, add/sub with guard bits, normalise, truncate.
  always_comb begin
    if (a_q[30:0] >= b_q[30:0]) begin
      sx = sa; ex = ea; mx_f = a_q[22:0];
      sy = sb; ey = eb; my_f = b_q[22:0];
    end else begin
      sx = sb; ex = eb; mx_f = b_q[22:0];
      sy = sa; ey = ea; my_f = a_q[22:0];
    end
    d    = ex - ey;
    dd   = (d > 8'd27) ? 5'd27 : d[4:0];
    mx   = {1'b1, mx_f, 3'b000};
    ext  = {1'b1, my_f, 30'b0} >> dd;
    my_s = ext[53:27] | {26'b0, |ext[26:0]};
    if (sx ^ sy) sum = {1'b0, mx} - {1'b0, my_s};
    else         sum = {1'b0, mx} + {1'b0, my_s};
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    if (sum[27]) begin
      nrm   = sum >> 1;
      e_add = $signed({2'b0, ex}) + 10'sd1;
    end else begin
      nrm   = sum << lz;
      e_add = $signed({2'b0, ex}) - $signed({5'b0, lz});
    end
    if (sum == 28'd0)          add_arith = 32'h0;
    else if (e_add >= 10'sd255) add_arith = {sx, 8'hFF, 23'b0};
    else if (e_add <= 10'sd0)   add_arith = {sx, 31'b0};
    else add_arith = {sx, e_add[7:0], nrm[25:3]};
  end

  // Add exception override in priority order.
  always_comb begin
    if (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb)))
      add_res = QNAN;
    else if (inf_a)            add_res = {sa, 8'hFF, 23'b0};
    else if (inf_b)            add_res = {sb, 8'hFF, 23'b0};
    else if (zero_a & zero_b)  add_res = {sa & sb, 31'b0};
    else if (zero_a)           add_res = fb;
    else if (zero_b)           add_res = fa;
    else                       add_res = add_arith;
  end

  logic [31:0] mul_res;
`ifdef FP32_ARITH_MULT_EN
  logic              sp;
  logic [47:0]       prod;
  logic [22:0]       pf;
  logic signed [9:0] e_mul;
  logic [31:0]       mul_arith;

  // Multiplier: 24x24 product, 1-bit normalise, truncate.
  always_comb begin
    sp   = sa ^ sb;
    prod = {1'b1, a_q[22:0]} * {1'b1, b_q[22:0]};
    e_mul = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
    if (prod[47]) begin
      pf    = prod[46:24];
      e_mul = e_mul + 10'sd1;
    end else begin
      pf = prod[45:23];
    end
    if (e_mul >= 10'sd255)    mul_arith = {sp, 8'hFF, 23'b0};
    else if (e_mul <= 10'sd0) mul_arith = {sp, 31'b0};
    else mul_arith = {sp, e_mul[7:0], pf};
    if (nan_a | nan_b | (zero_a & inf_b) | (inf_a & zero_b))
      mul_res = QNAN;
    else if (inf_a | inf_b)   mul_res = {sp, 8'hFF, 23'b0};
    else if (zero_a | zero_b) mul_res = {sp, 31'b0};
    else                      mul_res = mul_arith;
  end

  logic unused_mul;
  assign unused_mul = ^prod[22:0];
`else
  assign mul_res = QNAN;
`endif

  logic unused_add;
  assign unused_add = ^{nrm[27:26], nrm[2:0]};

  assign res_d = op_q ? mul_res : add_res;

  // Operand capture and registered result with one-cycle strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      op_q   <= 1'b0;
      v_q    <= 1'b0;
      data_q <= 32'h0;
      ov_q   <= 1'b0;
    end else begin
      v_q  <= In_Data_Valid;
      ov_q <= v_q;
      if (In_Data_Valid) begin
        a_q  <= Data1;
        b_q  <= Data2;
        op_q <= Op;
      end
      if (v_q) data_q <= res_d;
    end
  end

  assign Data_Out       = data_q;
  assign Out_Data_Valid = ov_q;
endmodule

// File: tb/tb_fp32_arith_unit.sv
// tb_fp32_arith_unit: scoreboard bench for fp32_arith_unit.
// Expected results and arrival cycles are queued by the driver.
module tb_fp32_arith_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d1, d2;
  logic        idv, op;
  logic [31:0] dout;
  logic        odv;

  fp32_arith_unit dut (
    .Clock(clk), .Reset(rst), .Data1(d1), .Data2(d2),
    .In_Data_Valid(idv), .Op(op),
    .Data_Out(dout), .Out_Data_Valid(odv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
    string       n;
  } exp_t;

  exp_t expq[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [31:0] last_exp = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mexp(input logic [31:0] v);
`ifdef FP32_ARITH_MULT_EN
    return v;
`else
    return 32'h7FC0_0000 | (v & 32'h0);
`endif
  endfunction

  // Monitor: pop and compare on every output strobe.
  always @(negedge clk) begin
    if (odv) begin
      exp_t e;
      compared++;
      if (expq.size() == 0) begin
        mismatched++;
        $display("FAIL stray_strobe: got %h, expected no strobe", dout);
      end else begin
        e = expq.pop_front();
        if (dout !== e.d) begin
          mismatched++;
          $display("FAIL %s: got %h, expected %h", e.n, dout, e.d);
        end
        compared++;
        if (cyc != e.c) begin
          mismatched++;
          $display("FAIL %s_latency: got cycle %0d, expected %0d",
                   e.n, cyc, e.c);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] x,
                       input string nm);
    exp_t e;
    d1 = a; d2 = b; op = o; idv = 1'b1;
    e.d = x; e.c = cyc + 2; e.n = nm;
    expq.push_back(e);
    last_exp = x;
    @(negedge clk);
    idv = 1'b0;
  endtask

  task automatic check(input logic [31:0] got, input logic [31:0] x,
                       input string nm);
    compared++;
    if (got !== x) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, got, x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    while (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no strobe, expected %h", e.n, e.d);
    end
  endtask

  initial begin
    rst = 1'b1; idv = 1'b0; op = 1'b0; d1 = 32'h0; d2 = 32'h0;
    repeat (3) @(negedge clk);
    check(dout, 32'h0, "reset_data");
    check({31'b0, odv}, 32'h0, "reset_valid");
    rst = 1'b0;
    @(negedge clk);

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "add_1_2");
    drain();
    issue(32'h3FC00000, 32'h40000000, 1'b1, mexp(32'h40400000), "mul_1p5_2");
    issue(32'h7F7FFFFF, 32'h40000000, 1'b1, mexp(32'h7F800000), "mul_ovf");
    issue(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, "inf_minus_inf");
    issue(32'h00000000, 32'h7F800000, 1'b1, 32'h7FC00000, "zero_x_inf");
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, "nan_add");
    issue(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, "cancel");
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, "negz_negz");
    issue(32'hC0000000, 32'h00000000, 1'b1, mexp(32'h80000000), "neg2_x_0");
    issue(32'h3F800000, 32'hB0800000, 1'b0, 32'h3F7FFFFF, "sub_trunc");
    issue(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, "ninf_add");
    issue(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, "sub_flush");
    issue(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, "sub_plus_1");
    issue(32'h00800000, 32'h00800000, 1'b1, mexp(32'h00000000), "mul_unf");
    drain();

    issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, "pipe_add0");
    issue(32'h40400000, 32'h40000000, 1'b1, mexp(32'h40C00000), "pipe_mul");
    issue(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, "pipe_add1");
    drain();
    repeat (3) @(negedge clk);
    check(dout, last_exp, "hold_data");

    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, "pre_rst");
    void'(expq.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check(dout, 32'h0, "rst_mid_data");
    check({31'b0, odv}, 32'h0, "rst_mid_valid");
    repeat (3) @(negedge clk);
    issue(32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, "post_rst");
    drain();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
